// File: rtl/mp_banked_fifo.sv
// Multi-port FIFO striped round-robin across NB single-write banks, zero-latency show-ahead reads.
// Define MP_BANKED_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module mp_banked_fifo_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

module mp_banked_fifo #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 8,
   parameter int NW        = 4,
   parameter int NR        = 2,
   parameter int NB        = 4,
   parameter int AFULL_THR = NB*DEPTH - NW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic [NW*WIDTH-1:0]          wr_data,
   input  logic [NW-1:0]                wr_en,
   output logic [NW-1:0]                wr_ok,
   output logic [NR*WIDTH-1:0]          rd_data,
   input  logic [NR-1:0]                rd_en,
   output logic [NR-1:0]                rd_ok,
   output logic [$clog2(NB*DEPTH):0]    count,
   output logic                         afull,
   output logic                         err_ovf,
   output logic                         err_udf
);
   localparam int CAP = NB*DEPTH;
   localparam int CW  = $clog2(CAP) + 1;
   localparam int PW  = $clog2(CAP);
   localparam int AW  = $clog2(DEPTH);
   localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

   logic [PW-1:0] hp_q, hp_d, tp_q, tp_d;
   logic [CW-1:0] count_q, count_d;
   logic          afull_q, afull_d;

   logic [NB-1:0]            bk_we;
   logic [NB-1:0][AW-1:0]    bk_waddr, bk_raddr;
   logic [NB-1:0][WIDTH-1:0] bk_wdata, bk_rdata;
   logic [BW-1:0]            wbk, rbk, dbk;
   int                       rank, n_acc, n_pop;
   logic                     run;

   for (genvar b = 0; b < NB; b++) begin : g_bank
      mp_banked_fifo_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
         .clk   (clk),
         .we    (bk_we[b]),
         .waddr (bk_waddr[b]),
         .wdata (bk_wdata[b]),
         .raddr (bk_raddr[b]),
         .rdata (bk_rdata[b])
      );
   end

   // Slot tp+r lands in bank (tp+r)%NB; ranks are distinct and < NB, so banks never collide.
   always_comb begin
      rank     = 0;
      n_acc    = 0;
      wbk      = '0;
      wr_ok    = '0;
      bk_we    = '0;
      bk_waddr = '0;
      bk_wdata = '0;
      for (int i = 0; i < NW; i++) begin
         wr_ok[i] = (CAP - int'(count_q)) > rank;
         if (wr_en[i] && wr_ok[i] && !clr) begin
            wbk           = BW'((int'(tp_q) + rank) % NB);
            bk_we[wbk]    = 1'b1;
            bk_waddr[wbk] = AW'(((int'(tp_q) + rank) % CAP) / NB);
            bk_wdata[wbk] = wr_data[i*WIDTH +: WIDTH];
         end
         if (wr_en[i] && wr_ok[i]) n_acc = n_acc + 1;
         if (wr_en[i]) rank = rank + 1;
      end
   end

   // Only the leading run of valid requests pops, so a gapped rd_en still drains its prefix.
   always_comb begin
      rbk      = '0;
      n_pop    = 0;
      run      = 1'b1;
      rd_ok    = '0;
      bk_raddr = '0;
      for (int j = 0; j < NR; j++) begin
         rd_ok[j]      = int'(count_q) > j;
         rbk           = BW'((int'(hp_q) + j) % NB);
         bk_raddr[rbk] = AW'(((int'(hp_q) + j) % CAP) / NB);
         if (run && rd_en[j] && rd_ok[j]) n_pop = n_pop + 1;
         else run = 1'b0;
      end
   end

   always_comb begin
      dbk     = '0;
      rd_data = '0;
      for (int j = 0; j < NR; j++) begin
         dbk = BW'((int'(hp_q) + j) % NB);
         if (rd_ok[j]) rd_data[j*WIDTH +: WIDTH] = bk_rdata[dbk];
      end
   end

   always_comb begin
      hp_d    = hp_q + PW'(n_pop);
      tp_d    = tp_q + PW'(n_acc);
      count_d = count_q + CW'(n_acc) - CW'(n_pop);
      if (clr) begin
         hp_d    = '0;
         tp_d    = '0;
         count_d = '0;
      end
      afull_d = int'(count_d) >= AFULL_THR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hp_q    <= '0;
         tp_q    <= '0;
         count_q <= '0;
         afull_q <= 1'b0;
      end else begin
         hp_q    <= hp_d;
         tp_q    <= tp_d;
         count_q <= count_d;
         afull_q <= afull_d;
      end
   end

   assign count = count_q;
   assign afull = afull_q;

`ifdef MP_BANKED_FIFO_ERR_EN
   logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
   logic udf, seen_gap;

   // Requests dropped by clr are not judged; errors only come from live traffic.
   always_comb begin
      udf      = 1'b0;
      seen_gap = 1'b0;
      for (int j = 0; j < NR; j++) begin
         if (rd_en[j] && (seen_gap || !rd_ok[j])) udf = 1'b1;
         if (!rd_en[j]) seen_gap = 1'b1;
      end
      err_ovf_d = err_ovf_q | (!clr && |(wr_en & ~wr_ok));
      err_udf_d = err_udf_q | (!clr && udf);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_mp_banked_fifo.sv
// Scoreboard bench for mp_banked_fifo: directed scenarios plus a pseudo-random streaming phase.
module tb_mp_banked_fifo;
   localparam int WIDTH = 32, DEPTH = 8, NW = 4, NR = 2, NB = 4;
   localparam int CAP = NB*DEPTH, THR = CAP - NW;
`ifdef MP_BANKED_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, clr;
   logic [NW*WIDTH-1:0] wr_data;
   logic [NW-1:0]       wr_en, wr_ok;
   logic [NR*WIDTH-1:0] rd_data;
   logic [NR-1:0]       rd_en, rd_ok;
   logic [5:0]          count;
   logic                afull, err_ovf, err_udf;

   mp_banked_fifo dut (
      .clk(clk), .rst(rst), .clr(clr),
      .wr_data(wr_data), .wr_en(wr_en), .wr_ok(wr_ok),
      .rd_data(rd_data), .rd_en(rd_en), .rd_ok(rd_ok),
      .count(count), .afull(afull), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   int          m_count;
   bit          m_afull, m_ovf, m_udf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every visible read lane is compared against the reference queue; pops follow the grant.
   initial forever begin
      bit run;
      @(negedge clk);
      if (rst || clr) exp_q.delete();
      else begin
         for (int j = 0; j < NR; j++) begin
            if (rd_ok[j] === 1'b1) begin
               if (exp_q.size() > j) chk("rd_data", rd_data[j*WIDTH +: WIDTH], exp_q[j]);
               else chk("rd_ok_beyond_ref", {31'b0, rd_ok[j]}, 32'd0);
            end else chk("rd_data_idle", rd_data[j*WIDTH +: WIDTH], 32'd0);
         end
         run = 1'b1;
         for (int j = 0; j < NR; j++) begin
            if (run && rd_en[j] && rd_ok[j] === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
            else run = 1'b0;
         end
      end
   end

   // One cycle: drive inputs, check pre-edge status at negedge, then advance the model.
   task automatic step(input logic [NW-1:0] we, input logic [31:0] base,
                       input logic [NR-1:0] re, input bit c, input bit r);
      logic [NW-1:0] e_wok;
      logic [NR-1:0] e_rok;
      int rk, n_acc, n_pop;
      bit run, gap, udf;
      wr_en = we; rd_en = re; clr = c; rst = r;
      for (int i = 0; i < NW; i++) wr_data[i*WIDTH +: WIDTH] = base + i;
      rk = 0;
      for (int i = 0; i < NW; i++) begin
         e_wok[i] = (CAP - m_count) > rk;
         rk += int'(we[i]);
      end
      for (int j = 0; j < NR; j++) e_rok[j] = m_count > j;
      @(negedge clk);
      chk("count", {26'b0, count}, m_count);
      chk("wr_ok", {28'b0, wr_ok}, {28'b0, e_wok});
      chk("rd_ok", {30'b0, rd_ok}, {30'b0, e_rok});
      chk("afull", {31'b0, afull}, {31'b0, m_afull});
      chk("err_ovf", {31'b0, err_ovf}, {31'b0, ERR_EN & m_ovf});
      chk("err_udf", {31'b0, err_udf}, {31'b0, ERR_EN & m_udf});
      @(posedge clk);
      #1;
      if (r) begin
         m_count = 0; m_afull = 0; m_ovf = 0; m_udf = 0;
      end else if (c) begin
         m_count = 0; m_afull = (0 >= THR);
      end else begin
         n_acc = 0; n_pop = 0; run = 1; gap = 0; udf = 0;
         for (int i = 0; i < NW; i++) begin
            if (we[i] && !e_wok[i]) m_ovf = 1;
            if (we[i] && e_wok[i]) begin
               exp_q.push_back(base + i);
               n_acc++;
            end
         end
         for (int j = 0; j < NR; j++) begin
            if (re[j] && (gap || !e_rok[j])) udf = 1;
            if (!re[j]) gap = 1;
            if (run && re[j] && e_rok[j]) n_pop++;
            else run = 0;
         end
         if (udf) m_udf = 1;
         m_count = m_count + n_acc - n_pop;
         m_afull = m_count >= THR;
      end
      wr_en = '0; rd_en = '0; clr = 0; rst = 0;
   endtask

   initial begin
      logic [NW-1:0] we;
      logic [NR-1:0] re;
      int guard;
      rst = 1; clr = 0; wr_en = '0; rd_en = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      m_count = 0; m_afull = 0; m_ovf = 0; m_udf = 0;

      step(4'b0000, 32'h0, 2'b00, 0, 0);          // reset state
      step(4'b1011, 32'hA0, 2'b00, 0, 0);         // A0,A1,A3 compacted
      step(4'b0000, 32'h0, 2'b11, 0, 0);          // count 3, see A0/A1, pop both
      step(4'b0000, 32'h0, 2'b01, 0, 0);          // pop A3
      step(4'b0001, 32'hB0, 2'b01, 0, 0);         // write into empty + read: underflow
      step(4'b0000, 32'h0, 2'b00, 0, 0);          // B0 now visible
      for (int k = 0; k < 7; k++) step(4'b1111, 32'h100 + 16*k, 2'b00, 0, 0);
      step(4'b0001, 32'h180, 2'b00, 0, 0);        // count 30
      step(4'b1111, 32'h200, 2'b00, 0, 0);        // only two fit
      step(4'b0001, 32'h300, 2'b11, 0, 0);        // full: pop 2, write rejected
      step(4'b0001, 32'h310, 2'b00, 0, 0);        // freed space accepts now

      for (int k = 0; k < 100; k++) begin
         we = NW'($urandom & $urandom);
         case ($urandom_range(0, 2))
            0: re = 2'b00;
            1: re = 2'b01;
            default: re = 2'b11;
         endcase
         step(we, 32'h1000 + 16*k, re, 0, 0);
      end

      guard = 0;
      while (m_count > 0 && guard < 40) begin
         step(4'b0000, 32'h0, (m_count > 1) ? 2'b11 : 2'b01, 0, 0);
         guard++;
      end
      chk("drain_bound", guard < 40, 1);
      step(4'b1111, 32'h4000, 2'b00, 0, 0);
      step(4'b1111, 32'h4010, 2'b00, 0, 0);
      step(4'b0011, 32'h4020, 2'b00, 0, 0);       // count 10
      step(4'b0000, 32'h0, 2'b10, 0, 0);          // gapped read: no pop, underflow
      step(4'b1111, 32'h5000, 2'b11, 1, 0);       // clr drops writes and reads
      step(4'b0000, 32'h0, 2'b00, 0, 0);          // count 0, flags unchanged
      step(4'b0011, 32'h6000, 2'b00, 0, 0);
      step(4'b1111, 32'h6100, 2'b11, 1, 1);       // rst wins over clr/traffic
      step(4'b0000, 32'h0, 2'b00, 0, 0);          // all cleared

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
